// File: rtl/cordic_sincos_core.sv
// ============================================================================
// Module   : cordic_sincos_core
// Brief    : Iterative Q16.16 CORDIC rotation engine producing cos/sin of an
//            angle in radians, one shift-add iteration per clock.
//            Optional quadrant folding: define CORDIC_QUADRANT_FOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sincos_core #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] angle_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out,
  output logic        range_err
);

  typedef enum logic [1:0] {IDLE, PREP, ROT, FIN} state_t;

  localparam logic signed [31:0] K_INIT  = 32'sh0000_9B75;
  localparam logic signed [31:0] PI      = 32'sd205887;
  localparam logic signed [31:0] HALF_PI = 32'sd102944;
  localparam logic [4:0]         LAST    = 5'(ITER - 1);

  state_t             state_q;
  logic               busy_q, done_q, rerr_q, err_q;
  logic signed [31:0] ang_q, x_q, y_q, z_q;
  logic signed [31:0] cos_q, sin_q;
  logic [4:0]         i_q;

  logic signed [31:0] x_d, y_d, z_d;
  logic signed [31:0] x_sh, y_sh, atan_i;
  logic signed [31:0] fold_z;
  logic               fold_err;
`ifdef CORDIC_QUADRANT_FOLD_EN
  logic               neg_q, fold_neg;
`endif

  // round(atan(2^-i) * 2^16); below 2^-8 the angle equals the shift itself.
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd51472;
      5'd1:    atan_lut = 32'sd30386;
      5'd2:    atan_lut = 32'sd16055;
      5'd3:    atan_lut = 32'sd8150;
      5'd4:    atan_lut = 32'sd4091;
      5'd5:    atan_lut = 32'sd2047;
      5'd6:    atan_lut = 32'sd1024;
      5'd7:    atan_lut = 32'sd512;
      default: atan_lut = (idx <= 5'd16) ? (32'sd1 <<< (5'd16 - idx)) : 32'sd0;
    endcase
  endfunction

  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(i_q);
    if (z_q[31]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_i;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_i;
    end
  end

  always_comb begin
    fold_z = ang_q;
`ifdef CORDIC_QUADRANT_FOLD_EN
    fold_neg = 1'b0;
    if (ang_q > HALF_PI) begin
      fold_z   = ang_q - PI;
      fold_neg = 1'b1;
    end else if (ang_q < -HALF_PI) begin
      fold_z   = ang_q + PI;
      fold_neg = 1'b1;
    end
    fold_err = (ang_q > PI) || (ang_q < -PI);
`else
    fold_err = (ang_q > HALF_PI) || (ang_q < -HALF_PI);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      ang_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
`ifdef CORDIC_QUADRANT_FOLD_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy_q is still high during the done cycle, so a start there is ignored
          if (start && !busy_q) begin
            ang_q   <= angle_in;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end else begin
            busy_q <= 1'b0;
          end
        end
        PREP: begin
          x_q     <= K_INIT;
          y_q     <= '0;
          z_q     <= fold_z;
          i_q     <= '0;
          err_q   <= fold_err;
`ifdef CORDIC_QUADRANT_FOLD_EN
          neg_q   <= fold_neg;
`endif
          state_q <= ROT;
        end
        ROT: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + 5'd1;
          if (i_q == LAST) state_q <= FIN;
        end
        FIN: begin
`ifdef CORDIC_QUADRANT_FOLD_EN
          cos_q <= neg_q ? -x_q : x_q;
          sin_q <= neg_q ? -y_q : y_q;
`else
          cos_q <= x_q;
          sin_q <= y_q;
`endif
          rerr_q  <= err_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign range_err = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sincos_core.sv
// ============================================================================
// Module   : tb_cordic_sincos_core
// Brief    : Directed self-checking bench for cordic_sincos_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sincos_core;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] angle_in;
  logic        busy, done, range_err;
  logic [31:0] cos_out, sin_out;

  int total = 0;
  int bad   = 0;
  int lat, dones, dk;

  cordic_sincos_core #(.ITER(16)) dut (
    .clk(clk), .reset(reset), .start(start), .angle_in(angle_in),
    .busy(busy), .done(done), .cos_out(cos_out), .sin_out(sin_out),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input int exp);
    int  diff;
    logic ok;
    diff = $signed(obs) - exp;
    ok   = (diff >= -16) && (diff <= 16);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-16", tag, $signed(obs), exp);
    end
  endtask

  // Issue one request and return the number of edges until done is seen.
  task automatic do_op(input logic [31:0] a, output int n);
    @(posedge clk); #1;
    start    = 1'b1;
    angle_in = a;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; angle_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_rerr", 32'(range_err), 0);
    reset = 1'b0;

    do_op(32'd0, lat);
    chk("zero_lat", lat, 18);
    chk("zero_busy_at_done", 32'(busy), 1);
    chk_near("zero_cos", cos_out, 65536);
    chk_near("zero_sin", sin_out, 0);
    chk("zero_rerr", 32'(range_err), 0);

    do_op(32'd34315, lat);
    chk("pi6_lat", lat, 18);
    chk_near("pi6_cos", cos_out, 56756);
    chk_near("pi6_sin", sin_out, 32768);

    do_op(-32'sd51472, lat);
    chk_near("mpi4_cos", cos_out, 46341);
    chk_near("mpi4_sin", sin_out, -46341);
    chk("mpi4_rerr", 32'(range_err), 0);

    do_op(32'd137258, lat);
`ifdef CORDIC_QUADRANT_FOLD_EN
    chk_near("2pi3_cos", cos_out, -32768);
    chk_near("2pi3_sin", sin_out, 56756);
    chk("2pi3_rerr", 32'(range_err), 0);
`else
    chk("2pi3_rerr", 32'(range_err), 1);
`endif

    do_op(32'd300000, lat);
    chk("big_lat", lat, 18);
    chk("big_rerr", 32'(range_err), 1);

    do_op(32'd0, lat);
    chk("clr_rerr", 32'(range_err), 0);
    chk_near("clr_cos", cos_out, 65536);

    // Restarts while busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; angle_in = 32'd34315;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; dk = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        dk = k;
      end
      start    = (k == 3) || (k == 10);
      angle_in = (k == 3) ? -32'sd51472 : 32'd137258;
    end
    start = 1'b0;
    chk("rs_dones", dones, 1);
    chk("rs_lat", dk, 18);
    chk_near("rs_cos", cos_out, 56756);
    chk_near("rs_sin", sin_out, 32768);
    chk("rs_busy", 32'(busy), 0);

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; angle_in = 32'd34315;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_cos", cos_out, 0);
    chk("ab_sin", sin_out, 0);
    chk("ab_rerr", 32'(range_err), 0);
    dones = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ab_no_done", dones, 0);

    do_op(-32'sd51472, lat);
    chk("post_lat", lat, 18);
    chk_near("post_cos", cos_out, 46341);
    chk_near("post_sin", sin_out, -46341);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
